// File: rtl/iosys_mem_arbiter.sv
// iosys_mem_arbiter
//   Shares the single iosys SDRAM port (rv_*) between three masters:
//   m0 firmware flash loader, m1 picorv32 core, m2 savestate/ROM DMA engine.
//   One transaction in flight at a time. The winner's address, write data and
//   strobes are registered at grant time and held until the downstream
//   completes. Fixed priority m0 > m1 > m2. A master that has lost AGE_LIMIT
//   arbitrations in a row is boosted above the fixed order, so none starves.
//
// Parameters
//   AGE_LIMIT       lost arbitrations before a master is boosted (1..15)
//   TIMEOUT_CYCLES  max rv_valid cycles without rv_ready (1..1023)
//
// Ports
//   clk, resetn            sole clock, asynchronous active-low reset
//   ram_busy               SDRAM initialising; no grants while high
//   mN_valid/addr/wdata/wstrb  master request (held until mN_ready), wstrb=0 is a read
//   mN_ready, mN_rdata     one-cycle completion pulse and read data
//   rv_valid/addr/wdata/wstrb  registered downstream request
//   rv_ready, rv_rdata     downstream completion pulse and read data
//   grant                  owner of current/last transaction
//   busy                   high in any state but IDLE
//   timeout_err            one-cycle pulse on an aborted transaction
//
// Build option
//   IOSYS_ARB_TIMEOUT_EN   when defined, a transaction whose rv_ready does not
//                          arrive within TIMEOUT_CYCLES is aborted and completed
//                          with rdata 32'hDEAD_BEEF and a timeout_err pulse.
//                          When undefined, ISSUE waits indefinitely and
//                          timeout_err is tied low.
//
// States
//   state    | meaning
//   ---------+------------------------------------------------------------
//   ST_IDLE  | no transaction; arbitrate and latch the winner's payload
//   ST_ISSUE | rv_valid high, payload stable, waiting for rv_ready
//   ST_ACK   | mN_ready pulse to the owner; no arbitration this cycle

module iosys_mem_arbiter #(
  parameter int unsigned AGE_LIMIT      = 15,
  parameter int unsigned TIMEOUT_CYCLES = 1023
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        ram_busy,
  input  logic        m0_valid,
  input  logic [22:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  output logic        m0_ready,
  output logic [31:0] m0_rdata,
  input  logic        m1_valid,
  input  logic [22:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  output logic        m1_ready,
  output logic [31:0] m1_rdata,
  input  logic        m2_valid,
  input  logic [22:0] m2_addr,
  input  logic [31:0] m2_wdata,
  input  logic [3:0]  m2_wstrb,
  output logic        m2_ready,
  output logic [31:0] m2_rdata,
  output logic        rv_valid,
  output logic [22:0] rv_addr,
  output logic [31:0] rv_wdata,
  output logic [3:0]  rv_wstrb,
  input  logic        rv_ready,
  input  logic [31:0] rv_rdata,
  output logic [1:0]  grant,
  output logic        busy,
  output logic        timeout_err
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_ACK   = 2'd2
  } state_t;

  localparam logic [3:0] AGE_MAX = 4'(AGE_LIMIT);

  if (AGE_LIMIT < 1 || AGE_LIMIT > 15 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 1023) begin : g_param_check
    $error("iosys_mem_arbiter: AGE_LIMIT must be 1..15 and TIMEOUT_CYCLES 1..1023");
  end

  state_t      state;
  logic [2:0]  req;
  logic [3:0]  age [3];
  logic [2:0]  boosted;
  logic [1:0]  win;
  logic        win_any;
  logic        do_grant;
  logic [22:0] win_addr;
  logic [31:0] win_wdata;
  logic [3:0]  win_wstrb;
  logic [2:0]  ready_q;
  logic [31:0] rdata_q [3];

`ifdef IOSYS_ARB_TIMEOUT_EN
  // Down-counter loaded on grant; terminal count 0 marks the last ISSUE cycle
  localparam logic [9:0] TMO_LOAD = 10'(TIMEOUT_CYCLES - 1);
  logic [9:0] tmo_cnt;
  logic       tmo_err_q;
  assign timeout_err = tmo_err_q;
`else
  assign timeout_err = 1'b0;
`endif

  assign req      = {m2_valid, m1_valid, m0_valid};
  assign win_any  = |req;
  assign do_grant = (state == ST_IDLE) && !ram_busy && win_any;
  assign busy     = (state != ST_IDLE);

  assign boosted = {req[2] && (age[2] == AGE_MAX),
                    req[1] && (age[1] == AGE_MAX),
                    req[0] && (age[0] == AGE_MAX)};

  // A boosted master beats every unboosted one; ties resolve by index
  always_comb begin
    if      (boosted[0]) win = 2'd0;
    else if (boosted[1]) win = 2'd1;
    else if (boosted[2]) win = 2'd2;
    else if (req[0])     win = 2'd0;
    else if (req[1])     win = 2'd1;
    else                 win = 2'd2;
  end

  always_comb begin
    case (win)
      2'd0: begin
        win_addr  = m0_addr;
        win_wdata = m0_wdata;
        win_wstrb = m0_wstrb;
      end
      2'd1: begin
        win_addr  = m1_addr;
        win_wdata = m1_wdata;
        win_wstrb = m1_wstrb;
      end
      default: begin
        win_addr  = m2_addr;
        win_wdata = m2_wdata;
        win_wstrb = m2_wstrb;
      end
    endcase
  end

  assign m0_ready = ready_q[0];
  assign m1_ready = ready_q[1];
  assign m2_ready = ready_q[2];
  assign m0_rdata = rdata_q[0];
  assign m1_rdata = rdata_q[1];
  assign m2_rdata = rdata_q[2];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= ST_IDLE;
      rv_valid <= 1'b0;
      rv_addr  <= '0;
      rv_wdata <= '0;
      rv_wstrb <= '0;
      grant    <= 2'd0;
      ready_q  <= '0;
      for (int i = 0; i < 3; i++) begin
        age[i]     <= '0;
        rdata_q[i] <= '0;
      end
`ifdef IOSYS_ARB_TIMEOUT_EN
      tmo_cnt   <= '0;
      tmo_err_q <= 1'b0;
`endif
    end else begin
      ready_q <= '0;
`ifdef IOSYS_ARB_TIMEOUT_EN
      tmo_err_q <= 1'b0;
`endif

      // An idle master forgets its waiting history; only valid losers age
      for (int i = 0; i < 3; i++) begin
        if (!req[i]) begin
          age[i] <= '0;
        end else if (do_grant) begin
          if (2'(i) == win) begin
            age[i] <= '0;
          end else if (age[i] != AGE_MAX) begin
            age[i] <= age[i] + 4'd1;
          end
        end
      end

      case (state)
        ST_IDLE: begin
          if (do_grant) begin
            rv_addr  <= win_addr;
            rv_wdata <= win_wdata;
            rv_wstrb <= win_wstrb;
            grant    <= win;
            rv_valid <= 1'b1;
            state    <= ST_ISSUE;
`ifdef IOSYS_ARB_TIMEOUT_EN
            tmo_cnt  <= TMO_LOAD;
`endif
          end
        end
        ST_ISSUE: begin
          // rv_ready on the expiry cycle still counts as a normal completion
          if (rv_ready) begin
            rdata_q[grant] <= rv_rdata;
            ready_q[grant] <= 1'b1;
            rv_valid       <= 1'b0;
            state          <= ST_ACK;
          end
`ifdef IOSYS_ARB_TIMEOUT_EN
          else if (tmo_cnt == '0) begin
            rdata_q[grant] <= 32'hDEAD_BEEF;
            ready_q[grant] <= 1'b1;
            tmo_err_q      <= 1'b1;
            rv_valid       <= 1'b0;
            state          <= ST_ACK;
          end else begin
            tmo_cnt <= tmo_cnt - 10'd1;
          end
`endif
        end
        ST_ACK: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_iosys_mem_arbiter.sv
`timescale 1ns/1ps
module tb_iosys_mem_arbiter;

  localparam int AGE = 2;
  localparam int TMO = 8;
  localparam int PH_FREE = 0;
  localparam int PH_INFL = 1;
  localparam int PH_ACK  = 2;

  logic        clk = 1'b0;
  logic        resetn;
  logic        ram_busy;
  logic        m_valid [3];
  logic [22:0] m_addr  [3];
  logic [31:0] m_wdata [3];
  logic [3:0]  m_wstrb [3];
  logic        m0_ready, m1_ready, m2_ready;
  logic [31:0] m0_rdata, m1_rdata, m2_rdata;
  logic        rv_valid;
  logic [22:0] rv_addr;
  logic [31:0] rv_wdata;
  logic [3:0]  rv_wstrb;
  logic        rv_ready;
  logic [31:0] rv_rdata;
  logic [1:0]  grant;
  logic        busy;
  logic        timeout_err;

  int errors = 0;
  int checks = 0;

  // reference model state
  int          ph;
  int          owner;
  int          wait_cnt;
  int          age_m     [3];
  bit          done_flag [3];
  bit          pend      [3];
  logic        exp_rv_valid;
  logic [1:0]  exp_grant;
  logic [22:0] exp_addr;
  logic [31:0] exp_wdata;
  logic [3:0]  exp_wstrb;
  logic        exp_ready [3];
  logic [31:0] exp_rdata [3];
  logic        exp_tmo;
  logic        exp_busy;

  iosys_mem_arbiter #(.AGE_LIMIT(AGE), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .resetn(resetn), .ram_busy(ram_busy),
    .m0_valid(m_valid[0]), .m0_addr(m_addr[0]), .m0_wdata(m_wdata[0]), .m0_wstrb(m_wstrb[0]),
    .m0_ready(m0_ready), .m0_rdata(m0_rdata),
    .m1_valid(m_valid[1]), .m1_addr(m_addr[1]), .m1_wdata(m_wdata[1]), .m1_wstrb(m_wstrb[1]),
    .m1_ready(m1_ready), .m1_rdata(m1_rdata),
    .m2_valid(m_valid[2]), .m2_addr(m_addr[2]), .m2_wdata(m_wdata[2]), .m2_wstrb(m_wstrb[2]),
    .m2_ready(m2_ready), .m2_rdata(m2_rdata),
    .rv_valid(rv_valid), .rv_addr(rv_addr), .rv_wdata(rv_wdata), .rv_wstrb(rv_wstrb),
    .rv_ready(rv_ready), .rv_rdata(rv_rdata),
    .grant(grant), .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    ph = PH_FREE;
    owner = 0;
    wait_cnt = 0;
    exp_rv_valid = 1'b0;
    exp_grant = 2'd0;
    exp_addr = '0;
    exp_wdata = '0;
    exp_wstrb = '0;
    exp_tmo = 1'b0;
    exp_busy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      age_m[i] = 0;
      done_flag[i] = 1'b0;
      exp_ready[i] = 1'b0;
      exp_rdata[i] = '0;
    end
  endtask

  // winner: first valid master that has waited AGE times, else first valid master
  function automatic int pick();
    for (int i = 0; i < 3; i++) if (m_valid[i] && age_m[i] == AGE) return i;
    for (int i = 0; i < 3; i++) if (m_valid[i]) return i;
    return -1;
  endfunction

  task automatic complete(input logic [31:0] d, input logic t);
    exp_rdata[owner] = d;
    exp_ready[owner] = 1'b1;
    done_flag[owner] = 1'b1;
    exp_rv_valid = 1'b0;
    exp_tmo = t;
    ph = PH_ACK;
  endtask

  // predicts what the coming clock edge does with the inputs now applied
  task automatic model_edge();
    int w;
    for (int i = 0; i < 3; i++) exp_ready[i] = 1'b0;
    exp_tmo = 1'b0;
    if (!resetn) begin
      model_reset();
    end else begin
      w = -1;
      if (ph == PH_FREE && !ram_busy) w = pick();
      for (int i = 0; i < 3; i++) begin
        if (!m_valid[i] || i == w) age_m[i] = 0;
        else if (w >= 0 && age_m[i] < AGE) age_m[i] = age_m[i] + 1;
      end
      if (ph == PH_FREE) begin
        if (w >= 0) begin
          owner = w;
          exp_grant = 2'(w);
          exp_addr = m_addr[w];
          exp_wdata = m_wdata[w];
          exp_wstrb = m_wstrb[w];
          exp_rv_valid = 1'b1;
          wait_cnt = 0;
          ph = PH_INFL;
        end
      end else if (ph == PH_INFL) begin
        if (rv_ready) begin
          complete(rv_rdata, 1'b0);
        end else begin
          wait_cnt++;
`ifdef IOSYS_ARB_TIMEOUT_EN
          if (wait_cnt == TMO) complete(32'hDEAD_BEEF, 1'b1);
`endif
        end
      end else begin
        ph = PH_FREE;
      end
      exp_busy = (ph != PH_FREE);
    end
  endtask

  task automatic check_all();
    chk("rv_valid", {31'd0, rv_valid}, {31'd0, exp_rv_valid});
    chk("grant", {30'd0, grant}, {30'd0, exp_grant});
    chk("busy", {31'd0, busy}, {31'd0, exp_busy});
    chk("timeout_err", {31'd0, timeout_err}, {31'd0, exp_tmo});
    chk("rv_addr", {9'd0, rv_addr}, {9'd0, exp_addr});
    chk("rv_wdata", rv_wdata, exp_wdata);
    chk("rv_wstrb", {28'd0, rv_wstrb}, {28'd0, exp_wstrb});
    chk("m0_ready", {31'd0, m0_ready}, {31'd0, exp_ready[0]});
    chk("m1_ready", {31'd0, m1_ready}, {31'd0, exp_ready[1]});
    chk("m2_ready", {31'd0, m2_ready}, {31'd0, exp_ready[2]});
    chk("m0_rdata", m0_rdata, exp_rdata[0]);
    chk("m1_rdata", m1_rdata, exp_rdata[1]);
    chk("m2_rdata", m2_rdata, exp_rdata[2]);
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic new_req(input int m);
    m_addr[m]  = 23'($urandom);
    m_wdata[m] = $urandom;
    m_wstrb[m] = ($urandom_range(1) == 0) ? 4'd0 : 4'($urandom);
    m_valid[m] = 1'b1;
    pend[m]    = 1'b1;
  endtask

  task automatic drain();
    for (int m = 0; m < 3; m++) begin
      m_valid[m] = 1'b0;
      pend[m] = 1'b0;
    end
    ram_busy = 1'b0;
    rv_ready = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    rv_ready = 1'b0;
    for (int m = 0; m < 3; m++) done_flag[m] = 1'b0;
  endtask

  initial begin
    int seq [6] = '{0, 0, 1, 0, 0, 1};
    int k;
    int ph_before;

    resetn = 1'b1;
    ram_busy = 1'b0;
    rv_ready = 1'b0;
    rv_rdata = '0;
    for (int m = 0; m < 3; m++) begin
      m_valid[m] = 1'b0;
      m_addr[m] = '0;
      m_wdata[m] = '0;
      m_wstrb[m] = '0;
      pend[m] = 1'b0;
    end
    model_reset();

    // reset values
    #2 resetn = 1'b0;
    #1 check_all();
    tick();
    resetn = 1'b1;
    tick();

    // ram_busy blocks grants; minimum latency read on m1
    ram_busy = 1'b1;
    m_valid[1] = 1'b1;
    m_addr[1] = 23'h000100;
    m_wdata[1] = '0;
    m_wstrb[1] = 4'd0;
    for (int i = 0; i < 3; i++) tick();
    chk("busy_hold_rv_valid", {31'd0, rv_valid}, 32'd0);
    ram_busy = 1'b0;
    tick();
    chk("a_grant", {30'd0, grant}, 32'd1);
    chk("a_addr", {9'd0, rv_addr}, 32'h000100);
    rv_ready = 1'b1;
    rv_rdata = 32'h12345678;
    tick();
    chk("a_ready", {31'd0, m1_ready}, 32'd1);
    chk("a_rdata", m1_rdata, 32'h12345678);
    rv_ready = 1'b0;
    m_valid[1] = 1'b0;
    done_flag[1] = 1'b0;
    tick();
    chk("a_ready_pulse", {31'd0, m1_ready}, 32'd0);

    // m0 and m1 contend continuously: age boost gives m1 every third grant
    m_valid[0] = 1'b1; m_addr[0] = 23'h000010; m_wdata[0] = '0; m_wstrb[0] = 4'd0;
    m_valid[1] = 1'b1; m_addr[1] = 23'h000020; m_wdata[1] = '0; m_wstrb[1] = 4'd0;
    rv_ready = 1'b1;
    rv_rdata = 32'hA5A50000;
    k = 0;
    for (int i = 0; i < 40 && k < 6; i++) begin
      ph_before = ph;
      tick();
      if (ph_before == PH_FREE && ph == PH_INFL) begin
        chk("age_seq", {30'd0, grant}, 32'(seq[k]));
        k++;
      end
      for (int m = 0; m < 2; m++) begin
        if (done_flag[m]) begin
          done_flag[m] = 1'b0;
          m_addr[m] = 23'($urandom);
        end
      end
      rv_rdata = $urandom;
    end
    chk("age_seq_count", 32'(k), 32'd6);
    drain();

    // m2 write: payload held stable until rv_ready; valid dropped mid-flight
    m_valid[2] = 1'b1;
    m_addr[2] = 23'h7F0000;
    m_wdata[2] = 32'hCAFEF00D;
    m_wstrb[2] = 4'b0100;
    tick();
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("c_wstrb", {28'd0, rv_wstrb}, 32'b0100);
      chk("c_addr", {9'd0, rv_addr}, 32'h7F0000);
    end
    m_valid[2] = 1'b0;
    rv_ready = 1'b1;
    rv_rdata = 32'h0BADF00D;
    tick();
    chk("c_ready", {31'd0, m2_ready}, 32'd1);
    chk("c_rdata", m2_rdata, 32'h0BADF00D);
    rv_ready = 1'b0;
    done_flag[2] = 1'b0;
    tick();

`ifdef IOSYS_ARB_TIMEOUT_EN
    // downstream never answers: abort after TMO cycles, then normal service
    m_valid[1] = 1'b1;
    m_addr[1] = 23'h000200;
    m_wstrb[1] = 4'd0;
    tick();
    for (int i = 0; i < TMO; i++) tick();
    chk("t_err", {31'd0, timeout_err}, 32'd1);
    chk("t_ready", {31'd0, m1_ready}, 32'd1);
    chk("t_rdata", m1_rdata, 32'hDEADBEEF);
    m_valid[1] = 1'b0;
    done_flag[1] = 1'b0;
    tick();
    m_valid[1] = 1'b1;
    m_addr[1] = 23'h000204;
    rv_ready = 1'b1;
    rv_rdata = 32'h55AA55AA;
    tick();
    tick();
    chk("t_next_rdata", m1_rdata, 32'h55AA55AA);
    m_valid[1] = 1'b0;
    done_flag[1] = 1'b0;
    rv_ready = 1'b0;
    tick();
`endif

    // randomized traffic against the model
    for (int c = 0; c < 2500; c++) begin
      for (int m = 0; m < 3; m++) begin
        if (done_flag[m]) begin
          done_flag[m] = 1'b0;
          pend[m] = 1'b0;
          m_valid[m] = 1'b0;
        end
        if (!pend[m] && $urandom_range(3) == 0) new_req(m);
        else if (pend[m] && m_valid[m] && ph == PH_INFL && owner == m && $urandom_range(15) == 0)
          m_valid[m] = 1'b0;
      end
      ram_busy = ($urandom_range(9) == 0);
      rv_ready = ($urandom_range(2) == 0);
      rv_rdata = $urandom;
      tick();
    end
    drain();

    // asynchronous reset while a transaction is in flight
    m_valid[0] = 1'b1;
    m_addr[0] = 23'h001234;
    m_wstrb[0] = 4'd0;
    tick();
    tick();
    chk("e_pre_rv_valid", {31'd0, rv_valid}, 32'd1);
    resetn = 1'b0;
    #1;
    chk("e_rv_valid", {31'd0, rv_valid}, 32'd0);
    chk("e_busy", {31'd0, busy}, 32'd0);
    chk("e_grant", {30'd0, grant}, 32'd0);
    model_reset();
    m_valid[0] = 1'b0;
    tick();
    resetn = 1'b1;
    tick();
    m_valid[2] = 1'b1;
    m_addr[2] = 23'h000ABC;
    m_wstrb[2] = 4'd0;
    rv_ready = 1'b1;
    rv_rdata = 32'h600DCAFE;
    tick();
    tick();
    chk("e_recover_rdata", m2_rdata, 32'h600DCAFE);
    m_valid[2] = 1'b0;
    rv_ready = 1'b0;
    done_flag[2] = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
